// File: rtl/demux1to9_stream.sv
// Registered 1-to-N stream demultiplexer.
// Each input word is routed to a one-entry holding register on the output channel
// selected by in_sel. Words with an out-of-range select are consumed and counted
// as drops in a saturating counter.
module demux1to9_stream #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned NUM_OUT = 9,
    parameter int unsigned SEL_W   = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [SEL_W-1:0]         in_sel,
    output logic [NUM_OUT-1:0]       out_valid,
    input  logic [NUM_OUT-1:0]       out_ready,
    output logic [NUM_OUT*WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]         drop_count,
    input  logic                     drop_clr
);

    logic [NUM_OUT-1:0]       sel_hit;
    logic [NUM_OUT-1:0]       push;
    logic                     xfer;
    logic                     drop;
    logic [NUM_OUT-1:0]       valid_q;
    logic [NUM_OUT*WIDTH-1:0] data_q;
    logic [CNT_W-1:0]         drop_cnt_q;

    // Decode select to one-hot; an out-of-range select decodes to all zeros.
    always_comb begin
        sel_hit = '0;
        for (int k = 0; k < int'(NUM_OUT); k++) begin
            sel_hit[k] = (32'(in_sel) == 32'(k));
        end
    end

    // Ready unless the selected channel is full and not draining this cycle.
    // in_valid is deliberately absent so ready never depends on it.
    always_comb begin
        in_ready = ~|(sel_hit & valid_q & ~out_ready);
        xfer     = in_valid & in_ready;
        push     = sel_hit & {NUM_OUT{xfer}};
        drop     = xfer & ~|sel_hit;
    end

    // Per-channel holding registers: push has priority over pop so a full channel
    // that drains and refills in the same cycle stays full with the new word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            for (int k = 0; k < int'(NUM_OUT); k++) begin
                if (push[k]) begin
                    valid_q[k]                <= 1'b1;
                    data_q[k*WIDTH +: WIDTH]  <= in_data;
                end else if (out_ready[k]) begin
                    // Data is left untouched on pop; only valid drops.
                    valid_q[k] <= 1'b0;
                end
            end
        end
    end

    // Saturating drop counter; clear wins over a simultaneous increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else if (drop_clr) begin
            drop_cnt_q <= '0;
        end else if (drop && (drop_cnt_q != {CNT_W{1'b1}})) begin
            drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_demux1to9_stream.sv
// Self-checking bench for demux1to9_stream: a per-channel behavioural model is
// compared against the DUT every cycle, plus directed scenarios with literal
// expectations and a randomized traffic phase.
module tb_demux1to9_stream;

    localparam int W = 16;
    localparam int N = 9;
    localparam int C = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic [3:0]     in_sel;
    logic [N-1:0]   out_valid;
    logic [N-1:0]   out_ready;
    logic [N*W-1:0] out_data;
    logic [C-1:0]   drop_count;
    logic           drop_clr;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Behavioural model: each channel is "holding a word or not", plus a drop tally.
    bit          m_full [N];
    logic [W-1:0] m_word [N];
    int          m_drops;

    demux1to9_stream dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .drop_count (drop_count),
        .drop_clr   (drop_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [N*W-1:0] act,
                         input logic [N*W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_ready(input logic [3:0] sel, input logic [N-1:0] ordy);
        if (int'(sel) >= N) return 1'b1;
        return !m_full[sel] || ordy[sel];
    endfunction

    function automatic logic [N-1:0] model_valid();
        logic [N-1:0] v;
        for (int k = 0; k < N; k++) v[k] = m_full[k];
        return v;
    endfunction

    function automatic logic [N*W-1:0] model_data();
        logic [N*W-1:0] d;
        for (int k = 0; k < N; k++) d[k*W +: W] = m_word[k];
        return d;
    endfunction

    // Model update on each edge from the inputs the DUT sees.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N; k++) begin
                m_full[k] = 1'b0;
                m_word[k] = '0;
            end
            m_drops = 0;
        end else begin
            bit acc;
            acc = in_valid && model_ready(in_sel, out_ready);
            for (int k = 0; k < N; k++) begin
                if (acc && int'(in_sel) == k) begin
                    m_full[k] = 1'b1;
                    m_word[k] = in_data;
                end else if (out_ready[k]) begin
                    m_full[k] = 1'b0;
                end
            end
            if (drop_clr) m_drops = 0;
            else if (acc && int'(in_sel) >= N) m_drops = (m_drops >= 255) ? 255 : m_drops + 1;
        end
    end

    // Cycle-by-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        if (chk_en && !reset) begin
            check("in_ready", N*W'(in_ready), N*W'(model_ready(in_sel, out_ready)));
            check("out_valid", N*W'(out_valid), N*W'(model_valid()));
            check("out_data", out_data, model_data());
            check("drop_count", N*W'(drop_count), N*W'(m_drops));
        end
    end

    task automatic drive(input logic v, input int sel, input logic [W-1:0] d,
                         input logic [N-1:0] ordy, input logic clr);
        in_valid  = v;
        in_sel    = 4'(sel);
        in_data   = d;
        out_ready = ordy;
        drop_clr  = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] exp_w;
        reset = 1'b1;
        drive(1'b0, 0, '0, '0, 1'b0);
        repeat (3) @(posedge clk);
        #7 reset = 1'b0;
        chk_en = 1'b1;
        #1;

        // Reset state and idle readiness for every select value.
        check("rst_valid", N*W'(out_valid), '0);
        check("rst_data", out_data, '0);
        check("rst_drops", N*W'(drop_count), '0);
        for (int s = 0; s < 16; s++) begin
            in_sel = 4'(s);
            #0.1;
            check("rst_ready", N*W'(in_ready), N*W'(1));
        end
        tick();

        // One word per channel with all consumers ready.
        for (int s = 0; s < N; s++) begin
            drive(1'b1, s, 16'h1000 + 16'(s), '1, 1'b0);
            tick();
            check("route_valid", N*W'(out_valid), N*W'(1 << s));
            check("route_data", N*W'(out_data[s*W +: W]), N*W'(16'h1000 + 16'(s)));
        end
        drive(1'b0, 0, '0, '1, 1'b0);
        tick();
        check("route_idle", N*W'(out_valid), '0);

        // Stall on channel 3.
        drive(1'b1, 3, 16'hABCD, 9'h1F7, 1'b0);
        tick();
        drive(1'b1, 3, 16'h1234, 9'h1F7, 1'b0);
        #1;
        check("stall_ready", N*W'(in_ready), '0);
        tick();
        check("stall_hold_v", N*W'(out_valid[3]), N*W'(1));
        check("stall_hold_d", N*W'(out_data[3*W +: W]), N*W'(16'hABCD));
        tick();
        check("stall_hold_d2", N*W'(out_data[3*W +: W]), N*W'(16'hABCD));
        out_ready = '1;
        #1;
        check("stall_release", N*W'(in_ready), N*W'(1));
        tick();
        check("stall_new_d", N*W'(out_data[3*W +: W]), N*W'(16'h1234));
        check("stall_new_v", N*W'(out_valid), N*W'(9'h008));
        drive(1'b0, 0, '0, '1, 1'b0);
        tick();

        // Back-to-back on channel 5.
        for (int i = 0; i < 10; i++) begin
            exp_w = 16'($urandom);
            drive(1'b1, 5, exp_w, '1, 1'b0);
            #1;
            check("b2b_ready", N*W'(in_ready), N*W'(1));
            tick();
            check("b2b_data", N*W'(out_data[5*W +: W]), N*W'(exp_w));
            check("b2b_valid", N*W'(out_valid), N*W'(9'h020));
        end
        drive(1'b0, 0, '0, '1, 1'b0);
        tick();

        // Drops and saturation.
        drive(1'b1, 9, 16'hFFFF, '1, 1'b0);
        tick();
        drive(1'b1, 15, 16'hFFFF, '1, 1'b0);
        tick();
        check("drop_two", N*W'(drop_count), N*W'(2));
        check("drop_novalid", N*W'(out_valid), '0);
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 9 + (i % 7), 16'(i), '1, 1'b0);
            tick();
        end
        check("drop_sat", N*W'(drop_count), N*W'(8'hFF));
        drive(1'b1, 10, 16'h0, '1, 1'b1);
        tick();
        check("drop_clr_wins", N*W'(drop_count), '0);
        drive(1'b0, 0, '0, '1, 1'b0);
        tick();

        // Fill channels 2 and 7, then asynchronous reset mid-cycle.
        drive(1'b1, 12, 16'h5555, '0, 1'b0);
        tick();
        drive(1'b1, 2, 16'h2222, '0, 1'b0);
        tick();
        drive(1'b1, 7, 16'h7777, '0, 1'b0);
        tick();
        drive(1'b0, 0, '0, '0, 1'b0);
        check("fill_valid", N*W'(out_valid), N*W'(9'h084));
        check("fill_drops", N*W'(drop_count), N*W'(1));
        #2 reset = 1'b1;
        #1;
        check("arst_valid", N*W'(out_valid), '0);
        check("arst_drops", N*W'(drop_count), '0);
        check("arst_data", out_data, '0);
        @(negedge clk);
        #1 reset = 1'b0;
        drive(1'b1, 4, 16'h4444, '1, 1'b0);
        tick();
        check("post_rst_v", N*W'(out_valid), N*W'(9'h010));
        check("post_rst_d", N*W'(out_data[4*W +: W]), N*W'(16'h4444));

        // Randomized traffic checked by the per-cycle comparison.
        for (int i = 0; i < 3000; i++) begin
            int s;
            s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(9, 15))
                                            : int'($urandom_range(0, 8));
            drive(1'($urandom), s, 16'($urandom), N'($urandom),
                  ($urandom_range(0, 31) == 0));
            tick();
        end
        drive(1'b0, 0, '0, '1, 1'b0);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/demux1to9_stream.md
Name: demux1to9_stream

Overview:
Registered 1-to-9 demultiplexer for 16-bit words; the distributing counterpart of the 9-to-1 select mux. It accepts one word per cycle on a valid/ready input together with a 4-bit destination select. It routes the word into a one-entry holding register on the selected output channel. Each channel presents its word on an independent valid/ready port. Words with an out-of-range select are consumed and counted as drops.

Parameters:
WIDTH, 16, data width of every word
NUM_OUT, 9, number of output channels (1..16; select codes >= NUM_OUT are invalid)
SEL_W, 4, select width
CNT_W, 8, width of drop counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  input word present
in_ready  output  1  block can accept input this cycle
in_data  input  WIDTH  input word
in_sel  input  SEL_W  destination channel (0..NUM_OUT-1 valid)
out_valid  output  NUM_OUT  per-channel word present
out_ready  input  NUM_OUT  per-channel consumer ready
out_data  output  NUM_OUT*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
drop_count  output  CNT_W  saturating count of words dropped for invalid select
drop_clr  input  1  synchronous clear of drop_count

Behaviour:
- Reset (async assert, any time): out_valid=0, out_data=0 on all channels, drop_count=0. In-flight words are lost. The first transfer is possible on the first rising edge after deassertion.
- Input handshake: transfer occurs when in_valid && in_ready at a rising clk edge. in_data and in_sel are sampled only on transfer.
- in_ready is combinational from in_sel, out_valid and out_ready, with no dependency on in_valid:
  - if in_sel >= NUM_OUT: in_ready=1
  - else: in_ready = !out_valid[in_sel] || out_ready[in_sel]
- Channel k state is a one-entry register: EMPTY (out_valid[k]=0) or FULL (out_valid[k]=1).
  - EMPTY, push -> FULL, out_data[k] = word. Latency is exactly 1 cycle from accept to out_valid.
  - FULL, out_ready[k]=1, no push -> EMPTY. out_data[k] holds its last value.
  - FULL, out_ready[k]=1, push same cycle -> stays FULL with the new word. Full throughput is 1 word/cycle per channel.
  - FULL, out_ready[k]=0 -> no push possible because in_ready=0. out_data[k] must remain stable.
- Only the selected channel changes on a push. Other channels pop independently in the same cycle.
- The output handshake is a standard valid/ready handshake. out_valid never deasserts without a pop, and out_data never changes while out_valid=1 && out_ready=0.
- Invalid select transfer: the word is discarded, no channel changes, and drop_count increments by 1. drop_count saturates at all-ones.
- drop_clr: on the next edge drop_count=0. Clear wins over a simultaneous drop increment.
- No combinational path from in_valid to any output. The in_ready path is from in_sel/out_valid/out_ready only.

Test Plan:
- Reset then idle -> out_valid=9'h000, out_data all 0, drop_count=0, in_ready=1 for every in_sel.
- Send sel=0..8 with data 16'h1000+sel, all out_ready=1 -> each word appears on channel sel one cycle after accept, with out_valid a one-cycle pulse; no other channel asserts.
- Hold out_ready[3]=0; send sel=3 data 16'hABCD, then sel=3 data 16'h1234 -> second word stalled (in_ready=0). Channel 3 holds 16'hABCD stable. Raise out_ready[3] -> in the same cycle 16'h1234 is accepted and presented next cycle.
- Back-to-back sel=5 every cycle with out_ready[5]=1 -> one word per cycle, in_ready constantly 1, data sequence preserved.
- Send sel=9, then sel=15, each with data 16'hFFFF -> no out_valid change, drop_count=2. Drive 300 invalid words -> drop_count=8'hFF. Assert drop_clr during a drop -> 0.
- Fill channels 2 and 7 with out_ready=0, then assert reset asynchronously mid-cycle -> out_valid=0 and drop_count=0 immediately. Normal routing resumes after release.
